// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with hardwired R0 and post-reset clear engine (optional REGFILE_BYPASS_EN write-through)
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_READ*ADDR_W-1:0] readReg,
  output logic [NUM_READ*DATA_W-1:0] readData,
  input  logic [ADDR_W-1:0]          writeReg0,
  input  logic [DATA_W-1:0]          writeData0,
  input  logic                       regWrite0,
  input  logic [ADDR_W-1:0]          writeReg1,
  input  logic [DATA_W-1:0]          writeData1,
  input  logic                       regWrite1,
  output logic                       ready
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_idx   <= ADDR_W'(1);
    end else if (r_state == CLEAR) begin
      r_idx <= r_idx + 1'b1;
      if (&r_idx) r_state <= RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR) r_mem[r_idx] <= '0;
      else begin
        if (regWrite0 && writeReg0 != '0) r_mem[writeReg0] <= writeData0;
        if (regWrite1 && writeReg1 != '0) r_mem[writeReg1] <= writeData1;
      end
    end
  end
  assign ready = (r_state == RUN);
  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    assign w_a = readReg[g*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign readData[g*DATA_W +: DATA_W] = (!ready || w_a == '0) ? '0 :
                                          (regWrite1 && writeReg1 == w_a) ? writeData1 :
                                          (regWrite0 && writeReg0 == w_a) ? writeData0 : r_mem[w_a];
`else
    assign readData[g*DATA_W +: DATA_W] = (!ready || w_a == '0) ? '0 : r_mem[w_a];
`endif
  end
endmodule
